spi_cmd_ctrl: RTL and testbench
===============================

SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter: ADDR_W, 6, register address width; command byte bits [ADDR_W-1:0] carry the address; ADDR_W SHALL be <= 6.
REQ-002 clk  input  1  peripheral clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 frame_active  input  1  high while the SPI chip select is asserted, already synchronised to clk.
REQ-005 byte_sync  input  1  one-clk pulse marking a completed received byte.
REQ-006 data_in  input  8  received byte, valid in the cycle byte_sync is high.
REQ-007 data_out  output  8  byte to shift out on the next SPI byte.
REQ-008 reg_addr  output  ADDR_W  register address.
REQ-009 reg_wdata  output  8  write data.
REQ-010 reg_wr  output  1  one-clk write strobe.
REQ-011 reg_rd  output  1  one-clk read strobe.
REQ-012 reg_rdata  input  8  read data, combinationally valid in the cycle reg_rd is high.

Function
REQ-013 FSM states SHALL be S_CMD (expect command byte) and S_DATA (expect data byte).
REQ-014 Command byte SHALL be decoded as: bit7 = rw (1 = write, 0 = read), bit6 reserved and ignored, bits[ADDR_W-1:0] = address.
REQ-015 In S_CMD, byte_sync SHALL latch rw and reg_addr and move the FSM to S_DATA.
REQ-016 For a read command, reg_rd SHALL pulse in the cycle after byte_sync, and data_out SHALL load reg_rdata on the following clock edge (valid 2 cycles after byte_sync).
REQ-017 In S_DATA with rw=1, byte_sync SHALL capture data_in into reg_wdata and pulse reg_wr in the next cycle at the latched reg_addr.
REQ-018 In S_DATA with rw=0, byte_sync SHALL complete the transaction; the received byte SHALL be discarded and no strobe SHALL be issued.
REQ-019 After a data byte, the FSM SHALL return to S_CMD unless REQ-027 applies.
REQ-020 frame_active low SHALL force the FSM to S_CMD and suppress any strobe not yet issued; data_out SHALL hold its value.
REQ-021 byte_sync in the same cycle that frame_active is low SHALL be ignored.
REQ-022 reg_wr and reg_rd SHALL never be high in the same cycle, and each SHALL last exactly one clk cycle.
REQ-023 A strobe already scheduled when frame_active falls SHALL still issue only if its triggering byte_sync arrived while frame_active was high.

Reset
REQ-024 rst high SHALL immediately set: FSM = S_CMD, data_out = 8'h00, reg_addr = 0, reg_wdata = 8'h00, reg_wr = 0, reg_rd = 0.
REQ-025 rst asserted mid-transaction SHALL cancel any pending strobe; after release, the first byte SHALL be treated as a command byte.

Configuration
REQ-026 Macro SPI_CMD_AUTOINC_EN SHALL select burst mode.
REQ-027 With the macro defined, the FSM SHALL stay in S_DATA after each data byte and increment reg_addr by 1 with modulo-2^ADDR_W wrap (all-ones -> 0).
REQ-028 With the macro defined, a read SHALL issue reg_rd at the incremented address in the cycle after each data byte_sync, and data_out SHALL reload from reg_rdata to prefetch the next byte.
REQ-029 Without the macro, each frame segment SHALL be exactly one command byte plus one data byte, and further bytes SHALL start a new command.

Verification
REQ-030 Write: frame high, byte 8'h85 then 8'h3C -> one reg_wr pulse with reg_addr=5, reg_wdata=8'h3C; no reg_rd.
REQ-031 Read: byte 8'h05 with reg_rdata=8'hA7 -> reg_rd one cycle after byte_sync with reg_addr=5, then data_out=8'hA7 the next cycle.
REQ-032 Abort: byte 8'h85, then frame_active low, then new frame with byte 8'h02 -> no reg_wr, and the new byte is decoded as a read of address 2.
REQ-033 Reset: rst pulse between the command and data bytes of a write -> all outputs zero, no reg_wr, and the next byte is decoded as a command.
REQ-034 Burst (macro on): 8'hBF then 8'h11, 8'h22 -> reg_wr at address 63 with 8'h11, then at address 0 with 8'h22 (wrap).
REQ-035 Simultaneous events: byte_sync in the same cycle that frame_active goes low -> byte ignored and FSM in S_CMD.

Source files
------------

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: SPI command-byte decoder driving a simple register-file strobe interface.
// Optional burst mode (address auto-increment) is enabled by defining SPI_CMD_AUTOINC_EN.
`default_nettype none

module spi_cmd_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_active,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata
);

  typedef enum logic [0:0] {
    S_CMD  = 1'b0,
    S_DATA = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t state;
  state_t state_next;
  logic   rw_latched;
  logic   byte_valid;

  // Bytes that complete while chip select is already gone are not part of any frame.
  assign byte_valid = byte_sync & frame_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CMD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!frame_active) begin
      state_next = S_CMD;
    end else if (byte_sync) begin
      case (state)
        S_CMD:   state_next = S_DATA;
`ifdef SPI_CMD_AUTOINC_EN
        S_DATA:  state_next = S_DATA;
`else
        S_DATA:  state_next = S_CMD;
`endif
        default: state_next = S_CMD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_latched <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= 8'h00;
      reg_wr     <= 1'b0;
      reg_rd     <= 1'b0;
      data_out   <= 8'h00;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;

      // Read data is combinational from the register file during the strobe cycle.
      if (reg_rd) begin
        data_out <= reg_rdata;
      end

`ifdef SPI_CMD_AUTOINC_EN
      // Writes post-increment so the strobe cycle still presents the target address.
      if (reg_wr) begin
        reg_addr <= reg_addr + ADDR_ONE;
      end
`endif

      if (byte_valid) begin
        case (state)
          S_CMD: begin
            rw_latched <= data_in[7];
            reg_addr   <= data_in[ADDR_W-1:0];
            reg_rd     <= ~data_in[7];
          end
          S_DATA: begin
            if (rw_latched) begin
              reg_wdata <= data_in;
              reg_wr    <= 1'b1;
            end else begin
`ifdef SPI_CMD_AUTOINC_EN
              // Prefetch the next location so it is ready for the following SPI byte.
              reg_addr <= reg_addr + ADDR_ONE;
              reg_rd   <= 1'b1;
`endif
            end
          end
          default: begin
            rw_latched <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: directed scenarios plus randomized frames against a transaction-level model.
`default_nettype none

module tb_spi_cmd_ctrl;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_active = 1'b0;
  logic          byte_sync = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_wr;
  logic          reg_rd;
  logic [7:0]    reg_rdata = 8'h00;

  int total = 0;
  int bad = 0;

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  spi_cmd_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .frame_active(frame_active),
    .byte_sync(byte_sync),
    .data_in(data_in),
    .data_out(data_out),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr(reg_wr),
    .reg_rd(reg_rd),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge just after the clock edge that saw byte_sync.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data_in   = b;
    byte_sync = 1'b1;
    @(negedge clk);
    byte_sync = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk);
    frame_active = 1'b0;
    @(negedge clk);
    frame_active = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    frame_active = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h want=00", data_out); end
    total++; if (reg_addr !== '0) begin bad++; $display("FAIL reset_reg_addr got=%h want=0", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_reg_wdata got=%h want=00", reg_wdata); end
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL reset_reg_wr got=%b want=0", reg_wr); end
    total++; if (reg_rd !== 1'b0) begin bad++; $display("FAIL reset_reg_rd got=%b want=0", reg_rd); end
    rst = 1'b0;
    frame_active = 1'b1;
  endtask

  task automatic test_write();
    send_byte(8'h85);
    total++; if (reg_wr !== 1'b0 || reg_rd !== 1'b0) begin bad++; $display("FAIL write_cmd_strobes got wr=%b rd=%b want wr=0 rd=0", reg_wr, reg_rd); end
    send_byte(8'h3C);
    total++; if (reg_wr !== 1'b1) begin bad++; $display("FAIL write_strobe got=%b want=1", reg_wr); end
    total++; if (reg_rd !== 1'b0) begin bad++; $display("FAIL write_no_rd got=%b want=0", reg_rd); end
    total++; if (reg_addr !== 6'd5) begin bad++; $display("FAIL write_addr got=%0d want=5", reg_addr); end
    total++; if (reg_wdata !== 8'h3C) begin bad++; $display("FAIL write_wdata got=%h want=3c", reg_wdata); end
    @(negedge clk);
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL write_one_cycle got=%b want=0", reg_wr); end
    end_frame();
  endtask

  task automatic test_read();
    reg_rdata = 8'hA7;
    send_byte(8'h05);
    total++; if (reg_rd !== 1'b1 || reg_wr !== 1'b0) begin bad++; $display("FAIL read_strobe got rd=%b wr=%b want rd=1 wr=0", reg_rd, reg_wr); end
    total++; if (reg_addr !== 6'd5) begin bad++; $display("FAIL read_addr got=%0d want=5", reg_addr); end
    @(negedge clk);
    total++; if (data_out !== 8'hA7) begin bad++; $display("FAIL read_data_out got=%h want=a7", data_out); end
    total++; if (reg_rd !== 1'b0) begin bad++; $display("FAIL read_one_cycle got=%b want=0", reg_rd); end
    end_frame();
  endtask

  task automatic test_abort();
    send_byte(8'h85);
    end_frame();
    reg_rdata = 8'h5A;
    send_byte(8'h02);
    total++; if (reg_wr !== 1'b0) begin bad++; $display("FAIL abort_no_wr got=%b want=0", reg_wr); end
    total++; if (reg_rd !== 1'b1 || reg_addr !== 6'd2) begin bad++; $display("FAIL abort_new_cmd got rd=%b addr=%0d want rd=1 addr=2", reg_rd, reg_addr); end
    @(negedge clk);
    total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL abort_data_out got=%h want=5a", data_out); end
    end_frame();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h85);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if ({data_out, reg_wdata, reg_wr, reg_rd} !== 18'h0 || reg_addr !== '0) begin
      bad++; $display("FAIL reset_mid_outputs got dout=%h addr=%h wd=%h wr=%b rd=%b want all zero", data_out, reg_addr, reg_wdata, reg_wr, reg_rd);
    end
    @(negedge clk);
    rst = 1'b0;
    reg_rdata = 8'hC3;
    send_byte(8'h3C);
    total++; if (reg_wr !== 1'b0 || reg_rd !== 1'b1 || reg_addr !== 6'd60) begin
      bad++; $display("FAIL reset_mid_cmd got wr=%b rd=%b addr=%0d want wr=0 rd=1 addr=60", reg_wr, reg_rd, reg_addr);
    end
    @(negedge clk);
    total++; if (data_out !== 8'hC3) begin bad++; $display("FAIL reset_mid_dout got=%h want=c3", data_out); end
    end_frame();
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    frame_active = 1'b0;
    data_in      = 8'h85;
    byte_sync    = 1'b1;
    @(negedge clk);
    byte_sync    = 1'b0;
    frame_active = 1'b1;
    total++; if (reg_wr !== 1'b0 || reg_rd !== 1'b0) begin bad++; $display("FAIL simul_ignored got wr=%b rd=%b want 0 0", reg_wr, reg_rd); end
    reg_rdata = 8'h96;
    send_byte(8'h03);
    total++; if (reg_rd !== 1'b1 || reg_addr !== 6'd3) begin bad++; $display("FAIL simul_cmd_state got rd=%b addr=%0d want rd=1 addr=3", reg_rd, reg_addr); end
    end_frame();
  endtask

  task automatic test_burst();
    send_byte(8'hBF);
    send_byte(8'h11);
    total++; if (reg_wr !== 1'b1 || reg_addr !== 6'd63 || reg_wdata !== 8'h11) begin
      bad++; $display("FAIL burst_first got wr=%b addr=%0d wd=%h want wr=1 addr=63 wd=11", reg_wr, reg_addr, reg_wdata);
    end
    @(negedge clk);
    send_byte(8'h22);
    total++; if (reg_wr !== 1'b1 || reg_addr !== 6'd0 || reg_wdata !== 8'h22) begin
      bad++; $display("FAIL burst_wrap got wr=%b addr=%0d wd=%h want wr=1 addr=0 wd=22", reg_wr, reg_addr, reg_wdata);
    end
    end_frame();
  endtask

  task automatic test_random();
    bit       in_data = 1'b0;
    bit       rw = 1'b0;
    int       addr = 0;
    int       dout = 0;
    int       wdata = 0;
    bit       exp_wr;
    bit       exp_rd;
    int       exp_saddr;
    logic [7:0] b;
    logic [7:0] rd;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_active = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        frame_active = 1'b0;
        data_in      = 8'($urandom);
        byte_sync    = 1'($urandom_range(0, 1));
        @(negedge clk);
        byte_sync    = 1'b0;
        frame_active = 1'b1;
        in_data = 1'b0;
      end else begin
        b  = 8'($urandom);
        rd = 8'($urandom);
        reg_rdata = rd;
        exp_wr = 1'b0;
        exp_rd = 1'b0;
        if (!in_data) begin
          rw      = b[7];
          addr    = int'(b) % 64;
          in_data = 1'b1;
          exp_rd  = !rw;
          exp_saddr = addr;
        end else if (rw) begin
          exp_wr    = 1'b1;
          wdata     = int'(b);
          exp_saddr = addr;
          if (BURST) addr = (addr + 1) % 64;
          else in_data = 1'b0;
        end else begin
          if (BURST) begin
            addr   = (addr + 1) % 64;
            exp_rd = 1'b1;
          end else begin
            in_data = 1'b0;
          end
          exp_saddr = addr;
        end
        if (exp_rd) dout = int'(rd);
        send_byte(b);
        total++; if (reg_wr !== exp_wr || reg_rd !== exp_rd || int'(reg_addr) != exp_saddr) begin
          bad++; $display("FAIL rand_strobe[%0d] got wr=%b rd=%b addr=%0d want wr=%b rd=%b addr=%0d", i, reg_wr, reg_rd, reg_addr, exp_wr, exp_rd, exp_saddr);
        end
        @(negedge clk);
        total++; if (int'(data_out) != dout || int'(reg_addr) != addr || int'(reg_wdata) != wdata || reg_wr !== 1'b0 || reg_rd !== 1'b0) begin
          bad++; $display("FAIL rand_state[%0d] got dout=%h addr=%0d wd=%h wr=%b rd=%b want dout=%h addr=%0d wd=%h wr=0 rd=0",
                          i, data_out, reg_addr, reg_wdata, reg_wr, reg_rd, dout[7:0], addr, wdata[7:0]);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reset_mid();
    test_simultaneous();
    if (BURST) test_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
